// File: rtl/vector_pkg.sv
// Shared types and constants for the vector line engine: FSM states,
// default coordinate width and the signed Bresenham error type.
package vector_pkg;

  localparam int COORD_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DRAW   = 2'd2
  } state_t;

  // Two extra bits hold the sign and the doubled error term e2 = 2*err.
  typedef logic signed [COORD_W_DEFAULT+1:0] err_t;

endpackage

// File: rtl/vector_line_engine_if.sv
// Command/beam bundle between the sequencer (master) and the vector line
// engine (slave).
interface vector_line_engine_if #(
  parameter int COORD_W = vector_pkg::COORD_W_DEFAULT
);
  // Handshake: draw/jump are single-cycle requests; a request is taken on a
  // clk edge where ready=1, and (x,y) are sampled on that edge. Requests
  // seen while ready=0 are dropped, not queued. jump wins over draw.
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               draw;
  logic               jump;
  logic               ready;
  logic [COORD_W-1:0] beam_x;
  logic [COORD_W-1:0] beam_y;
  logic               beam_on;

  modport master (
    output x, y, draw, jump,
    input  ready, beam_x, beam_y, beam_on
  );

  modport slave (
    input  x, y, draw, jump,
    output ready, beam_x, beam_y, beam_on
  );
endinterface

// File: rtl/bresenham_stepper.sv
// Bresenham point generator: load latches start/end and the error terms,
// each step advances one point; done flags that the end point is reached.
module bresenham_stepper #(
  parameter int COORD_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               done
);
  typedef logic signed [COORD_W+1:0] serr_t;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] end_x, end_y, adx, ady, x_nxt, y_nxt;
  serr_t              dx, dy, err, e2, err_nxt;
  logic               sx_neg, sy_neg;

  assign adx  = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
  assign ady  = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
  assign done = (cur_x == end_x) && (cur_y == end_y);

  always_comb begin
    e2      = err <<< 1;
    err_nxt = err;
    x_nxt   = cur_x;
    y_nxt   = cur_y;
    // Both axis moves are tested against the pre-step e2 and may both fire.
    if (e2 >= dy) begin
      err_nxt = err_nxt + dy;
      x_nxt   = sx_neg ? (cur_x - ONE) : (cur_x + ONE);
    end
    if (e2 <= dx) begin
      err_nxt = err_nxt + dx;
      y_nxt   = sy_neg ? (cur_y - ONE) : (cur_y + ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_x  <= '0;
      cur_y  <= '0;
      end_x  <= '0;
      end_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (load) begin
      cur_x  <= x0;
      cur_y  <= y0;
      end_x  <= x1;
      end_y  <= y1;
      dx     <= $signed({2'b00, adx});
      dy     <= -$signed({2'b00, ady});
      err    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
      sx_neg <= (x1 < x0);
      sy_neg <= (y1 < y0);
    end else if (step) begin
      cur_x <= x_nxt;
      cur_y <= y_nxt;
      err   <= err_nxt;
    end
  end
endmodule

// File: rtl/vector_line_engine.sv
// Vector line engine: takes draw/jump commands and drives the beam position
// and enable. Build option BEAM_SETTLE_EN stretches the blanked hold after a jump.
module vector_line_engine
  import vector_pkg::*;
#(
  parameter int COORD_W       = COORD_W_DEFAULT,
  parameter int STEP_DIV      = 1,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  vector_line_engine_if.slave   bus,
  output state_t                dbg_state
);
  localparam logic [7:0] DIV_LAST  = 8'(STEP_DIV - 1);
  localparam int         SETTLE_W  = $clog2(SETTLE_CYCLES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);
`ifdef BEAM_SETTLE_EN
  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES < 1) ? 0 : SETTLE_CYCLES - 1);
`else
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = '0;
`endif

  state_t               state, next_state;
  logic [COORD_W-1:0]   pos_x, pos_y, cur_x, cur_y;
  logic [7:0]           div_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic                 accept_jump, accept_draw, step_tick, pt_done;

  assign accept_jump = (state == IDLE) && bus.jump;
  assign accept_draw = (state == IDLE) && bus.draw && !bus.jump;
  assign step_tick   = (state == DRAW) && (div_cnt == DIV_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.jump)      next_state = SETTLE;
        else if (bus.draw) next_state = DRAW;
      end
      SETTLE: if (settle_cnt == SETTLE_LAST) next_state = IDLE;
      DRAW:   if (step_tick && pt_done)      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // pos holds the resting beam; on a draw it already takes the target,
  // while the stepper supplies the visible point until the line ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      div_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      state <= next_state;
      if (accept_jump || accept_draw) begin
        pos_x <= bus.x;
        pos_y <= bus.y;
      end
      if (state != DRAW || step_tick) div_cnt <= '0;
      else                            div_cnt <= div_cnt + 8'd1;
      if (state == SETTLE) settle_cnt <= settle_cnt + SETTLE_ONE;
      else                 settle_cnt <= '0;
    end
  end

  bresenham_stepper #(.COORD_W(COORD_W)) u_stepper (
    .clk   (clk),
    .reset (reset),
    .load  (accept_draw),
    .step  (step_tick && !pt_done),
    .x0    (pos_x),
    .y0    (pos_y),
    .x1    (bus.x),
    .y1    (bus.y),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .done  (pt_done)
  );

  assign bus.ready   = (state == IDLE);
  assign bus.beam_on = (state == DRAW);
  assign bus.beam_x  = (state == DRAW) ? cur_x : pos_x;
  assign bus.beam_y  = (state == DRAW) ? cur_y : pos_y;
  assign dbg_state   = state;
endmodule
